touch_sampler: RTL and testbench
================================

TOUCH_SAMPLER -- requirements
Module: touch_sampler

Interface
REQ-001 Parameter DATA_W, default 10, ADC sample width in bits.
REQ-002 Parameter AVG_LOG2, default 4, log2 of samples averaged per axis; legal range 0..8.
REQ-003 Parameter SETTLE_CYC, default 1000, plate-settling cycles after switching drive; legal range >= 1.
REQ-004 Parameter TOUCH_MIN, default 16, minimum averaged code on both axes to report a touch.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 runs continuous X/Y frames, 0 stops the sampler.
REQ-008 drive_x  output  1  1 energises X plates for an X read.
REQ-009 drive_y  output  1  1 energises Y plates for a Y read.
REQ-010 adc_start  output  1  one-cycle conversion request pulse.
REQ-011 adc_chan  output  1  channel for the request: 0 = X, 1 = Y; held stable until adc_done.
REQ-012 adc_done  input  1  one-cycle pulse, conversion complete, adc_data valid in the same cycle.
REQ-013 adc_data  input  DATA_W  conversion result.
REQ-014 x_coord  output  DATA_W  latest averaged X code.
REQ-015 y_coord  output  DATA_W  latest averaged Y code.
REQ-016 valid  output  1  one-cycle pulse; x_coord, y_coord and touched updated this cycle.
REQ-017 touched  output  1  1 when the latest frame has both averages >= TOUCH_MIN.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE_X, CONV_X, SETTLE_Y, CONV_Y, PUBLISH.
REQ-019 IDLE: drive_x = drive_y = 0; when enable = 1, go to SETTLE_X and clear both accumulators and the sample counter.
REQ-020 SETTLE_X/SETTLE_Y: assert the matching drive line only; after exactly SETTLE_CYC cycles in the state, go to CONV_X/CONV_Y.
REQ-021 CONV_x: hold the drive line; pulse adc_start for one cycle, then wait for adc_done; only one request outstanding; the next adc_start is issued no earlier than the cycle after adc_done.
REQ-022 On each adc_done in CONV_x, add adc_data to that axis's accumulator of width DATA_W+AVG_LOG2 (overflow impossible) and increment the sample counter.
REQ-023 After the 2^AVG_LOG2-th sample: CONV_X goes to SETTLE_Y with the counter cleared; CONV_Y goes to PUBLISH.
REQ-024 drive_x and drive_y SHALL never be 1 in the same cycle; switching between them passes through the settle state.
REQ-025 PUBLISH (one cycle): x_coord = X accumulator >> AVG_LOG2 (truncating); y_coord likewise; touched is set per REQ-017; valid = 1. Then go to SETTLE_X with cleared accumulators if enable = 1, else IDLE.
REQ-026 adc_done in any state other than CONV_x waiting SHALL be ignored.
REQ-027 enable = 0 in any state other than PUBLISH: go to IDLE next cycle, discard the partial frame, do not pulse valid, and keep x_coord, y_coord and touched unchanged.
REQ-028 enable = 0 during PUBLISH: the publish completes, then IDLE.
REQ-029 Frame latency from the SETTLE_X entry to valid, with a fixed ADC latency of L cycles from adc_start to adc_done: 2*SETTLE_CYC + 2*2^AVG_LOG2*(L+1) + 1 cycles.

Reset
REQ-030 While reset = 1: state IDLE; drive_x, drive_y, adc_start, adc_chan, valid, touched = 0; x_coord, y_coord, accumulators and counters = 0.
REQ-031 Reset mid-conversion SHALL abandon the request; any adc_done after reset releases is ignored per REQ-026.

Structure
REQ-032 The state enumeration and drive/channel encodings SHALL live in a shared package, touch_pkg.
REQ-033 One sub-module, axis_accumulator (clear, add-enable, data in, count out, sum out), instantiated once per axis.

Verification
All scenarios use DATA_W=10, AVG_LOG2=2, SETTLE_CYC=4, TOUCH_MIN=16, and an ADC model with L=3.
REQ-034 Constant X=400 and Y=300 -> valid after 4+4+4*4*2+1 = 41 cycles from SETTLE_X entry; x_coord=400, y_coord=300, touched=1.
REQ-035 X samples 1,2,3,5 -> x_coord=2 (truncation); Y samples 1023 x4 -> y_coord=1023 (no overflow).
REQ-036 X=10, Y=500 -> touched=0, valid still pulses; the next frame with X=20, Y=500 -> touched=1.
REQ-037 Drop enable during the 3rd CONV_Y sample -> IDLE next cycle, no valid, outputs keep prior frame values, drive lines both 0.
REQ-038 Assert reset mid CONV_X with a pending adc_done -> all outputs 0; the late adc_done is ignored; a new frame after release gives correct averages.
REQ-039 Every cycle -> assertion holds that drive_x and drive_y are never both 1 and adc_start never pulses while a conversion is outstanding.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared definitions for the resistive touch-panel sampler.
// Contents: FSM state enumeration, plate-drive and ADC-channel encodings,
// axis indices and small decode helpers used by the top level.
package touch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_X,
    CONV_X,
    SETTLE_Y,
    CONV_Y,
    PUBLISH
  } state_t;

  // One-hot plate drive so the two lines can never be energised together.
  typedef enum logic [1:0] {
    DRV_NONE = 2'b00,
    DRV_X    = 2'b01,
    DRV_Y    = 2'b10
  } drive_t;

  localparam logic CHAN_X = 1'b0;
  localparam logic CHAN_Y = 1'b1;

  localparam int AX_X     = 0;
  localparam int AX_Y     = 1;
  localparam int NUM_AXES = 2;

  function automatic drive_t drive_of(state_t s);
    case (s)
      SETTLE_X, CONV_X: return DRV_X;
      SETTLE_Y, CONV_Y: return DRV_Y;
      default:          return DRV_NONE;
    endcase
  endfunction

  // Channel follows the Y half of the frame so it stays put for a whole read.
  function automatic logic chan_of(state_t s);
    return (s == SETTLE_Y || s == CONV_Y) ? CHAN_Y : CHAN_X;
  endfunction

endpackage

// File: rtl/touch_sampler_if.sv
// Touch sampler bus: run control, plate drive, ADC request/response and
// the published coordinate frame.
//   master : sampler side (drives plates, ADC requests, results)
//   slave  : environment side (enable, ADC model, result consumer)
interface touch_sampler_if #(
  parameter int DATA_W = 10
);
  logic              enable;
  logic              drive_x;
  logic              drive_y;
  logic              adc_start;
  logic              adc_chan;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] x_coord;
  logic [DATA_W-1:0] y_coord;
  logic              valid;
  logic              touched;

  modport master (
    input  enable, adc_done, adc_data,
    output drive_x, drive_y, adc_start, adc_chan,
           x_coord, y_coord, valid, touched
  );

  modport slave (
    output enable, adc_done, adc_data,
    input  drive_x, drive_y, adc_start, adc_chan,
           x_coord, y_coord, valid, touched
  );
endinterface

// File: rtl/touch_sampler_axis_accumulator.sv
// Per-axis sample accumulator.
//   clk, reset : clock, async active-high reset
//   clear      : zero sum and count (wins over add_en)
//   add_en     : add data to sum and bump count
//   data       : ADC sample
//   count      : samples taken since clear
//   sum        : running total, wide enough for 2^AVG_LOG2 full-scale samples
module axis_accumulator #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       add_en,
  input  logic [DATA_W-1:0]          data,
  output logic [AVG_LOG2:0]          count,
  output logic [DATA_W+AVG_LOG2-1:0] sum
);
  localparam int ACC_W = DATA_W + AVG_LOG2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sum   <= '0;
    end else if (clear) begin
      count <= '0;
      sum   <= '0;
    end else if (add_en) begin
      count <= count + 1'b1;
      sum   <= sum + ACC_W'(data);
    end
  end
endmodule

// File: rtl/touch_sampler.sv
// Resistive touch-panel sampler. Runs continuous frames while enabled:
// settle X plates, take 2^AVG_LOG2 X conversions, settle Y plates, take
// 2^AVG_LOG2 Y conversions, then publish the truncated averages for one
// cycle together with a touch flag.
//   clk, reset : clock, async active-high reset
//   bus        : touch_sampler_if.master (enable, plate drive, ADC
//                handshake, x_coord/y_coord/valid/touched)
module touch_sampler
  import touch_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int AVG_LOG2   = 4,
  parameter int SETTLE_CYC = 1000,
  parameter int TOUCH_MIN  = 16
) (
  input  logic           clk,
  input  logic           reset,
  touch_sampler_if.master bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  LAST_SMP    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DATA_W-1:0] TMIN        = DATA_W'(TOUCH_MIN);

  state_t state, state_nx;

  logic [SET_W-1:0]                   settle_cnt;
  logic                               pending;
  logic                               acc_clr;
  logic                               in_conv, in_settle;
  logic                               start, take, last, axis;
  logic [NUM_AXES-1:0]                add_en;
  logic [NUM_AXES-1:0][CNT_W-1:0]     cnt;
  logic [NUM_AXES-1:0][ACC_W-1:0]     sum;
  logic [DATA_W-1:0]                  x_avg, y_avg, x_hold, y_hold;
  logic                               touch_now, touch_hold;
  drive_t                             drv;

  assign in_conv   = (state == CONV_X)   || (state == CONV_Y);
  assign in_settle = (state == SETTLE_X) || (state == SETTLE_Y);
  assign axis      = (state == CONV_Y);

  // Only a conversion we requested is accepted; strays are dropped.
  assign take  = in_conv && pending && bus.adc_done;
  assign last  = take && (cnt[axis] == LAST_SMP);
  // No new request on the cycle we are being told to stop.
  assign start = in_conv && !pending && bus.enable;

  assign add_en[AX_X] = take && (state == CONV_X);
  assign add_en[AX_Y] = take && (state == CONV_Y);

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    axis_accumulator #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clear  (acc_clr),
      .add_en (add_en[a]),
      .data   (bus.adc_data),
      .count  (cnt[a]),
      .sum    (sum[a])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_clr  = 1'b0;
    unique case (state)
      IDLE:     if (bus.enable) begin
                  state_nx = SETTLE_X;
                  acc_clr  = 1'b1;
                end
      SETTLE_X: if (settle_cnt == SETTLE_LAST) state_nx = CONV_X;
      CONV_X:   if (last) state_nx = SETTLE_Y;
      SETTLE_Y: if (settle_cnt == SETTLE_LAST) state_nx = CONV_Y;
      CONV_Y:   if (last) state_nx = PUBLISH;
      PUBLISH:  if (bus.enable) begin
                  state_nx = SETTLE_X;
                  acc_clr  = 1'b1;
                end else begin
                  state_nx = IDLE;
                end
      default:  state_nx = IDLE;
    endcase
    // A dropped enable abandons the frame; a publish in flight still lands.
    if (!bus.enable && state != PUBLISH) begin
      state_nx = IDLE;
      acc_clr  = 1'b0;
    end
  end

  // Counts cycles spent in the current settle state; restarts on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               settle_cnt <= '0;
    else if (in_settle && state_nx == state) settle_cnt <= settle_cnt + 1'b1;
    else                                     settle_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pending <= 1'b0;
    else if (start)            pending <= 1'b1;
    else if (take || !in_conv) pending <= 1'b0;
  end

  assign x_avg     = DATA_W'(sum[AX_X] >> AVG_LOG2);
  assign y_avg     = DATA_W'(sum[AX_Y] >> AVG_LOG2);
  assign touch_now = (x_avg >= TMIN) && (y_avg >= TMIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_hold     <= '0;
      y_hold     <= '0;
      touch_hold <= 1'b0;
    end else if (state == PUBLISH) begin
      x_hold     <= x_avg;
      y_hold     <= y_avg;
      touch_hold <= touch_now;
    end
  end

  // Fresh averages are presented in the publish cycle itself, then held.
  assign drv           = drive_of(state);
  assign bus.drive_x   = (drv == DRV_X);
  assign bus.drive_y   = (drv == DRV_Y);
  assign bus.adc_start = start;
  assign bus.adc_chan  = chan_of(state);
  assign bus.valid     = (state == PUBLISH);
  assign bus.x_coord   = bus.valid ? x_avg     : x_hold;
  assign bus.y_coord   = bus.valid ? y_avg     : y_hold;
  assign bus.touched   = bus.valid ? touch_now : touch_hold;
endmodule

// File: tb/tb_touch_sampler.sv
module tb_touch_sampler;
  localparam int DATA_W     = 10;
  localparam int AVG_LOG2   = 2;
  localparam int SETTLE_CYC = 4;
  localparam int TOUCH_MIN  = 16;
  localparam int L          = 3;

  // Frame timeline in cycles from SETTLE_X entry, derived from the rules.
  localparam int N        = 1 << AVG_LOG2;
  localparam int P        = L + 1;
  localparam int CONV_LEN = N * P;
  localparam int XC0      = SETTLE_CYC;
  localparam int YC0      = 2 * SETTLE_CYC + CONV_LEN;
  localparam int PUB      = 2 * SETTLE_CYC + 2 * CONV_LEN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  touch_sampler_if #(.DATA_W(DATA_W)) bus ();

  touch_sampler #(
    .DATA_W     (DATA_W),
    .AVG_LOG2   (AVG_LOG2),
    .SETTLE_CYC (SETTLE_CYC),
    .TOUCH_MIN  (TOUCH_MIN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ADC model state
  logic [DATA_W-1:0] x_src[$];
  logic [DATA_W-1:0] y_src[$];
  bit                adc_busy = 1'b0;
  int                adc_due  = -1;
  logic [DATA_W-1:0] adc_val  = '0;

  function automatic logic [DATA_W-1:0] rnd_sample();
    if ($urandom_range(0, 3) == 0) return DATA_W'($urandom_range(0, 31));
    return DATA_W'($urandom_range(0, 1023));
  endfunction

  // Cycle counter and ADC response drive, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == adc_due) begin
        bus.adc_done = 1'b1;
        bus.adc_data = adc_val;
      end else begin
        bus.adc_done = 1'b0;
        bus.adc_data = DATA_W'($urandom_range(0, 1023));
      end
    end
  end

  // Reference model: frame position, per-axis sums, held results.
  bit m_active = 1'b0;
  int m_t = 0, m_sx = 0, m_sy = 0, m_hx = 0, m_hy = 0;
  bit m_ht = 1'b0;

  bit act, in_xc, in_yc, e_valid, e_dx, e_dy, e_start, et;
  int ex, ey;

  always @(negedge clk) begin
    act     = m_active && !reset;
    in_xc   = act && m_t >= XC0 && m_t < XC0 + CONV_LEN;
    in_yc   = act && m_t >= YC0 && m_t < YC0 + CONV_LEN;
    e_valid = act && m_t == PUB;
    e_dx    = act && m_t < XC0 + CONV_LEN;
    e_dy    = act && m_t >= XC0 + CONV_LEN && m_t < PUB;
    e_start = (in_xc && ((m_t - XC0) % P == 0)) || (in_yc && ((m_t - YC0) % P == 0));
    if (reset) begin
      ex = 0; ey = 0; et = 1'b0;
    end else if (e_valid) begin
      ex = m_sx >> AVG_LOG2;
      ey = m_sy >> AVG_LOG2;
      et = (ex >= TOUCH_MIN) && (ey >= TOUCH_MIN);
    end else begin
      ex = m_hx; ey = m_hy; et = m_ht;
    end

    chk("drive_x", bus.drive_x == e_dx, int'(bus.drive_x), int'(e_dx));
    chk("drive_y", bus.drive_y == e_dy, int'(bus.drive_y), int'(e_dy));
    chk("drive_excl", !(bus.drive_x && bus.drive_y), int'(bus.drive_x && bus.drive_y), 0);
    if (bus.enable)
      chk("adc_start", bus.adc_start == e_start, int'(bus.adc_start), int'(e_start));
    if (in_xc || in_yc)
      chk("adc_chan", bus.adc_chan == in_yc, int'(bus.adc_chan), int'(in_yc));
    chk("valid", bus.valid == e_valid, int'(bus.valid), int'(e_valid));
    chk("x_coord", int'(bus.x_coord) == ex, int'(bus.x_coord), ex);
    chk("y_coord", int'(bus.y_coord) == ey, int'(bus.y_coord), ey);
    chk("touched", bus.touched == et, int'(bus.touched), int'(et));

    // ADC bookkeeping: one request at a time, response L cycles later.
    if (bus.adc_start) begin
      chk("adc_overlap", !adc_busy, int'(adc_busy), 0);
      adc_busy = 1'b1;
      adc_due  = cyc + L;
      if (bus.adc_chan == 1'b0) adc_val = (x_src.size() > 0) ? x_src.pop_front() : rnd_sample();
      else                      adc_val = (y_src.size() > 0) ? y_src.pop_front() : rnd_sample();
    end else if (bus.adc_done) begin
      adc_busy = 1'b0;
    end

    // Advance the model by one cycle.
    if (reset) begin
      m_active = 1'b0; m_hx = 0; m_hy = 0; m_ht = 1'b0;
    end else begin
      if (in_xc && ((m_t - XC0) % P == L)) m_sx += int'(bus.adc_data);
      if (in_yc && ((m_t - YC0) % P == L)) m_sy += int'(bus.adc_data);
      if (!m_active) begin
        if (bus.enable) begin m_active = 1'b1; m_t = 0; m_sx = 0; m_sy = 0; end
      end else if (m_t == PUB) begin
        m_hx = ex; m_hy = ey; m_ht = et;
        if (bus.enable) begin m_t = 0; m_sx = 0; m_sy = 0; end
        else m_active = 1'b0;
      end else if (!bus.enable) begin
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic wait_valid(output int vc, output int xv, output int yv, output int tv);
    vc = -1; xv = -1; yv = -1; tv = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        vc = cyc; xv = int'(bus.x_coord); yv = int'(bus.y_coord); tv = int'(bus.touched);
        return;
      end
    end
    chk("valid_timeout", 1'b0, 0, 1);
  endtask

  task automatic load(input int xs[4], input int ys[4]);
    for (int i = 0; i < 4; i++) begin
      x_src.push_back(DATA_W'(xs[i]));
      y_src.push_back(DATA_W'(ys[i]));
    end
  endtask

  int vc, xv, yv, tv, st, nval;

  initial begin
    reset = 1'b1;
    bus.enable   = 1'b0;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x_coord", bus.x_coord == 0, int'(bus.x_coord), 0);
    chk("rst_y_coord", bus.y_coord == 0, int'(bus.y_coord), 0);
    chk("rst_outs", {bus.drive_x, bus.drive_y, bus.adc_start, bus.adc_chan, bus.valid, bus.touched} == 6'b0,
        int'({bus.drive_x, bus.drive_y, bus.adc_start, bus.adc_chan, bus.valid, bus.touched}), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Constant frame, latency from SETTLE_X entry.
    load('{400, 400, 400, 400}, '{300, 300, 300, 300});
    bus.enable = 1'b1;
    st = cyc + 1;
    wait_valid(vc, xv, yv, tv);
    chk("lat_const", vc - st + 1 == 41, vc - st + 1, 41);
    chk("x_const", xv == 400, xv, 400);
    chk("y_const", yv == 300, yv, 300);
    chk("t_const", tv == 1, tv, 1);

    // Truncation and full-scale.
    load('{1, 2, 3, 5}, '{1023, 1023, 1023, 1023});
    wait_valid(vc, xv, yv, tv);
    chk("x_trunc", xv == 2, xv, 2);
    chk("y_full", yv == 1023, yv, 1023);

    // Below-threshold X, then just above.
    load('{10, 10, 10, 10}, '{500, 500, 500, 500});
    wait_valid(vc, xv, yv, tv);
    chk("t_low", tv == 0, tv, 0);
    chk("x_low", xv == 10, xv, 10);
    load('{20, 20, 20, 20}, '{500, 500, 500, 500});
    wait_valid(vc, xv, yv, tv);
    chk("t_high", tv == 1, tv, 1);
    chk("x_high", xv == 20, xv, 20);

    // Drop enable during the third Y conversion of the following frame.
    repeat (YC0 + 2 * P + 2) @(posedge clk);
    #1 bus.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_drive", !bus.drive_x && !bus.drive_y, int'({bus.drive_x, bus.drive_y}), 0);
    chk("abort_x", bus.x_coord == 20, int'(bus.x_coord), 20);
    chk("abort_y", bus.y_coord == 500, int'(bus.y_coord), 500);
    chk("abort_t", bus.touched == 1'b1, int'(bus.touched), 1);
    nval = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) nval++;
    end
    chk("abort_no_valid", nval == 0, nval, 0);

    // Reset with a conversion outstanding; first X sample is abandoned.
    @(posedge clk); #1;
    x_src.push_back(DATA_W'(999));
    load('{100, 104, 108, 112}, '{50, 51, 52, 53});
    bus.enable = 1'b1;
    repeat (XC0 + 2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_x", bus.x_coord == 0, int'(bus.x_coord), 0);
    chk("rst_mid_y", bus.y_coord == 0, int'(bus.y_coord), 0);
    chk("rst_mid_outs", {bus.drive_x, bus.adc_start, bus.valid, bus.touched} == 4'b0,
        int'({bus.drive_x, bus.adc_start, bus.valid, bus.touched}), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    wait_valid(vc, xv, yv, tv);
    chk("x_after_rst", xv == 106, xv, 106);
    chk("y_after_rst", yv == 51, yv, 51);
    chk("t_after_rst", tv == 1, tv, 1);

    // Random data frames, then random enable/reset activity.
    for (int f = 0; f < 4; f++) wait_valid(vc, xv, yv, tv);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) bus.enable = !bus.enable;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
